// File: rtl/pfrx_pkg.sv
// Shared types and sizing helpers for the parity frame receiver.
// Used by parity_frame_rx and parity_calc.
package pfrx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } pfrx_state_t;

    // Bit counter width for a given word size, never narrower than 1
    function automatic int pfrx_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int PFRX_DATA_W = 4;
    localparam int PFRX_CNT_W  = pfrx_cnt_w(PFRX_DATA_W);

    localparam logic [7:0] PFRX_ERR_MAX = 8'hFF;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity check over a received word and its parity bit.
// perr is 1 when data, parity bit and the odd/even selector disagree.
module parity_calc
    import pfrx_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic [DATA_W-1:0] data,
    input  logic              p_rx,
    output logic              perr
);

    localparam logic ODD = (PARITY_ODD != 0);

    assign perr = (^data) ^ p_rx ^ ODD;

endmodule

// File: rtl/parity_frame_rx.sv
// Framed serial receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional saturating error counter output enabled by PFRX_ERR_CNT_EN.
module parity_frame_rx
    import pfrx_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_ferr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
`ifdef PFRX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = pfrx_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    pfrx_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              p_rx;
    logic              perr_new;
    logic              ferr_new;
    logic              complete;
    logic              accept;

    parity_calc #(
        .DATA_W     (DATA_W),
        .PARITY_ODD (PARITY_ODD)
    ) u_parity (
        .data (shreg),
        .p_rx (p_rx),
        .perr (perr_new)
    );

    assign complete = bit_en && (state == STOP);
    assign ferr_new = ~rx_in;
    assign accept   = out_valid && out_ready;

    // Frame FSM and deserialiser, advancing only on bit strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            p_rx  <= 1'b0;
        end else if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    shreg[cnt] <= rx_in;
                    if (cnt == LAST) begin
                        state <= PARITY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    p_rx  <= rx_in;
                    state <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output buffer; a full, unaccepted buffer drops new frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_perr  <= 1'b0;
            out_ferr  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (complete && (!out_valid || out_ready)) begin
            out_data  <= shreg;
            out_perr  <= perr_new;
            out_ferr  <= ferr_new;
            out_valid <= 1'b1;
        end else if (complete) begin
            overrun <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PFRX_ERR_CNT_EN
    // Saturating count of completed frames with any error, dropped or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (complete && (perr_new || ferr_new)
                     && (err_cnt != PFRX_ERR_MAX)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx (even and odd parity instances).
// Define PFRX_ERR_CNT_EN to also exercise the error counter.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       rx_in = 1'b1;
    logic       out_ready = 1'b0;

    logic [3:0] out_data, out_data_o;
    logic       out_perr, out_perr_o;
    logic       out_ferr, out_ferr_o;
    logic       out_valid, out_valid_o;
    logic       overrun, overrun_o;
`ifdef PFRX_ERR_CNT_EN
    logic [7:0] err_cnt, err_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int model_cnt_e = 0;
    int model_cnt_o = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(4), .PARITY_ODD(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .rx_in     (rx_in),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .out_ferr  (out_ferr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef PFRX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    parity_frame_rx #(.DATA_W(4), .PARITY_ODD(1)) dut_o (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .rx_in     (rx_in),
        .out_data  (out_data_o),
        .out_perr  (out_perr_o),
        .out_ferr  (out_ferr_o),
        .out_valid (out_valid_o),
        .out_ready (out_ready),
        .overrun   (overrun_o)
`ifdef PFRX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt_o)
`endif
    );

    typedef struct {
        logic [3:0] d;
        logic       p;
        logic       s;
        logic [3:0] ed;
        logic       epe;
        logic       epo;
        logic       efe;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Parity rule from the frame definition: count ones in data + parity
    function automatic logic model_perr(input logic [3:0] d, input logic p,
                                        input bit odd);
        int n;
        n = $countones(d) + int'(p);
        return odd ? (n % 2 == 0) : (n % 2 == 1);
    endfunction

    function automatic int sat_inc(input int c);
        return (c < 255) ? c + 1 : 255;
    endfunction

    task automatic send_bit(input logic b, input int gap);
        rx_in = b;
        repeat (gap) begin
            bit_en = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p,
                              input logic s, input int gap,
                              input logic rdy_at_stop,
                              output logic pre_valid);
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        pre_valid = out_valid;
        if (rdy_at_stop) out_ready = 1'b1;
        send_bit(s, gap);
        if (rdy_at_stop) out_ready = 1'b0;
        rx_in = 1'b1;
        if (model_perr(d, p, 1'b0) || !s) model_cnt_e = sat_inc(model_cnt_e);
        if (model_perr(d, p, 1'b1) || !s) model_cnt_o = sat_inc(model_cnt_o);
    endtask

    task automatic check_frame(input string tag, input logic [3:0] d,
                               input logic pe, input logic po,
                               input logic fe);
        chk({tag, " valid"}, out_valid, 1'b1);
        chk({tag, " data"}, out_data, d);
        chk({tag, " perr"}, out_perr, pe);
        chk({tag, " ferr"}, out_ferr, fe);
        chk({tag, " odd data"}, out_data_o, d);
        chk({tag, " odd perr"}, out_perr_o, po);
        chk({tag, " odd ferr"}, out_ferr_o, fe);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " valid after accept"}, out_valid, 1'b0);
        chk({tag, " odd valid after accept"}, out_valid_o, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " data"}, out_data, 4'h0);
        chk({tag, " perr"}, out_perr, 1'b0);
        chk({tag, " ferr"}, out_ferr, 1'b0);
        chk({tag, " valid"}, out_valid, 1'b0);
        chk({tag, " overrun"}, overrun, 1'b0);
`ifdef PFRX_ERR_CNT_EN
        chk({tag, " err_cnt"}, err_cnt, 8'h00);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        model_cnt_e = 0;
        model_cnt_o = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       pv;
        logic [3:0] d;
        logic       p;
        logic       s;
        int         gap;

        vecs[0] = '{4'hB, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'hB, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'h7, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'h8, 1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0};

        #1;
        check_zero("initial reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: good, bad parity, framing error, recovery
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s, 0, 1'b0, pv);
            chk($sformatf("vec%0d valid before stop", i), pv, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i].ed, vecs[i].epe,
                        vecs[i].epo, vecs[i].efe);
            accept($sformatf("vec%0d", i));
        end

        // Completion on the same edge as acceptance replaces the entry
        send_frame(4'h1, 1'b1, 1'b1, 0, 1'b0, pv);
        check_frame("same-edge first", 4'h1, 1'b0, 1'b1, 1'b0);
        send_frame(4'h2, 1'b1, 1'b1, 0, 1'b1, pv);
        check_frame("same-edge second", 4'h2, 1'b0, 1'b1, 1'b0);
        chk("same-edge overrun", overrun, 1'b0);
        accept("same-edge");

        // Full buffer: second frame dropped, overrun sticky
        send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0, pv);
        check_frame("ovr first", 4'h3, 1'b0, 1'b1, 1'b0);
        chk("ovr before drop", overrun, 1'b0);
        send_frame(4'h6, 1'b0, 1'b1, 0, 1'b0, pv);
        check_frame("ovr held", 4'h3, 1'b0, 1'b1, 1'b0);
        chk("ovr set", overrun, 1'b1);
        chk("ovr odd set", overrun_o, 1'b1);
        accept("ovr");
        chk("ovr sticky", overrun, 1'b1);

        // Leave a frame buffered, then reset in the middle of another
        send_frame(4'h9, 1'b0, 1'b1, 0, 1'b0, pv);
        check_frame("pre-reset", 4'h9, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 2);
        send_bit(1'b0, 2);
        send_bit(1'b1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid-frame reset");
        chk("mid-frame reset odd valid", out_valid_o, 1'b0);
        model_cnt_e = 0;
        model_cnt_o = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(4'hA, 1'b0, 1'b1, 2, 1'b0, pv);
        chk("post-reset valid before stop", pv, 1'b0);
        check_frame("post-reset", 4'hA, 1'b0, 1'b1, 1'b0);
        chk("post-reset overrun", overrun, 1'b0);
        accept("post-reset");

        // Random frames, strobe gaps and consumer delays vs. parity model
        for (int n = 0; n < 40; n++) begin
            d   = 4'($urandom_range(0, 15));
            p   = 1'($urandom_range(0, 1));
            s   = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) begin
                bit_en = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            bit_en = 1'b0;
            send_frame(d, p, s, gap, 1'b0, pv);
            check_frame($sformatf("rand%0d", n), d, model_perr(d, p, 1'b0),
                        model_perr(d, p, 1'b1), ~s);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk($sformatf("rand%0d data held", n), out_data, d);
            accept($sformatf("rand%0d", n));
        end
        chk("rand overrun", overrun, 1'b0);

`ifdef PFRX_ERR_CNT_EN
        chk("rand err_cnt", err_cnt, model_cnt_e);
        chk("rand odd err_cnt", err_cnt_o, model_cnt_o);

        do_reset();
        for (int n = 0; n < 3; n++) begin
            send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0, pv);
            accept($sformatf("cnt%0d", n));
        end
        chk("err_cnt three", err_cnt, 8'd3);
        chk("odd err_cnt three", err_cnt_o, model_cnt_o);

        // Dropped error frames still count
        send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0, pv);
        send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0, pv);
        chk("err_cnt dropped", err_cnt, 8'd5);
        chk("err_cnt dropped model", err_cnt, model_cnt_e);
        chk("dropped overrun", overrun, 1'b1);
        accept("dropped");

        out_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send_frame(4'h0, 1'b1, 1'b1, 0, 1'b0, pv);
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("err_cnt saturated", err_cnt, 8'hFF);
        chk("err_cnt sat model", err_cnt, model_cnt_e);
        chk("odd err_cnt no errors", err_cnt_o, model_cnt_o);
        send_frame(4'h0, 1'b1, 1'b0, 0, 1'b0, pv);
        send_frame(4'h0, 1'b1, 1'b0, 0, 1'b0, pv);
        chk("err_cnt holds", err_cnt, 8'hFF);
        chk("odd err_cnt ferr", err_cnt_o, model_cnt_o);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
